// File: rtl/boothmul_r4_if.sv
// Request/result bundle for the radix-4 Booth multiplier: level arm/fin handshake,
// operands with per-operation signedness, and the product with its status flags.
interface boothmul_r4_if #(
  parameter int A1_LEN = 32,
  parameter int A2_LEN = 32
);
  logic                     arm;
  logic                     signed_mode;
  logic [A1_LEN-1:0]        a1;
  logic [A2_LEN-1:0]        a2;
  logic [A1_LEN+A2_LEN-1:0] outn;
  logic                     busy;
  logic                     fin;

  modport master (output arm, signed_mode, a1, a2, input outn, busy, fin);
  modport slave  (input arm, signed_mode, a1, a2, output outn, busy, fin);
endinterface

// File: rtl/boothmul_r4.sv
// Sequential radix-4 (modified) Booth multiplier: retires two multiplier bits per
// clock, exact product in signed or unsigned mode, level-sensitive arm/fin handshake.
module boothmul_r4 #(
  parameter int A1_LEN  = 32,
  parameter int A2_LEN  = 32,
  parameter int CNT_SIZ = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  boothmul_r4_if.slave  bus
);
  localparam int ITER = (A2_LEN + 2) / 2;
  localparam int YW   = 2 * ITER;
  localparam int HW   = A1_LEN + 3;
  localparam int W    = HW + YW + 1;
  localparam int PW   = A1_LEN + A2_LEN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  logic [CNT_SIZ-1:0]  cnt, cnt_nx;
  logic [HW-1:0]       mcand, mcand_nx;
  logic [W-1:0]        acc, acc_nx;
  logic [PW-1:0]       outn_r, outn_nx;
  logic                busy_r, busy_nx;
  logic                fin_r, fin_nx;

  logic signed [A1_LEN:0] m_ext;
  logic signed [A2_LEN:0] y_ext;
  logic [YW-1:0]          y_full;
  logic [HW-1:0]          term;
  logic [HW-1:0]          sum;
  logic signed [W-1:0]    pre_shift;
  logic [W-1:0]           acc_step;

  // Operand extension: one extra bit makes unsigned operands look signed to the recoder
  always_comb begin
    m_ext  = {bus.signed_mode & bus.a1[A1_LEN-1], bus.a1};
    y_ext  = {bus.signed_mode & bus.a2[A2_LEN-1], bus.a2};
    y_full = YW'(y_ext);
  end

  // One Booth step: recode the low triplet, add into the upper field, shift right by two
  always_comb begin
    term = '0;
    case (acc[2:0])
      3'b001, 3'b010: term = mcand;
      3'b011:         term = mcand << 1;
      3'b100:         term = -(mcand << 1);
      3'b101, 3'b110: term = -mcand;
      default:        term = '0;
    endcase
    sum       = acc[W-1 -: HW] + term;
    pre_shift = {sum, acc[YW:0]};
    acc_step  = pre_shift >>> 2;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mcand_nx = mcand;
    acc_nx   = acc;
    outn_nx  = outn_r;
    busy_nx  = busy_r;
    fin_nx   = fin_r;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        fin_nx  = 1'b0;
        if (bus.arm) begin
          mcand_nx = HW'(m_ext);
          acc_nx   = {{HW{1'b0}}, y_full, 1'b0};
          cnt_nx   = '0;
          busy_nx  = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!bus.arm) begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          acc_nx = acc_step;
          cnt_nx = cnt + 1'b1;
          if (cnt == CNT_SIZ'(ITER - 1)) begin
            outn_nx  = acc_step[PW:1];
            busy_nx  = 1'b0;
            fin_nx   = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        if (!bus.arm) begin
          fin_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        busy_nx  = 1'b0;
        fin_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      outn_r <= '0;
      busy_r <= 1'b0;
      fin_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      mcand  <= mcand_nx;
      acc    <= acc_nx;
      outn_r <= outn_nx;
      busy_r <= busy_nx;
      fin_r  <= fin_nx;
    end
  end

  assign bus.outn = outn_r;
  assign bus.busy = busy_r;
  assign bus.fin  = fin_r;
endmodule

// File: tb/tb_boothmul_r4.sv
// Bench for boothmul_r4: a 32x32 and a 7x5 instance checked against an arithmetic
// reference product, with directed literal vectors, abort, async reset and an exhaustive sweep.
module tb_boothmul_r4;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  logic [63:0] exp32;
  logic [11:0] exp7;

  boothmul_r4_if #(.A1_LEN(32), .A2_LEN(32)) b32 ();
  boothmul_r4_if #(.A1_LEN(7),  .A2_LEN(5))  b7 ();

  boothmul_r4 #(.A1_LEN(32), .A2_LEN(32), .CNT_SIZ(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );
  boothmul_r4 #(.A1_LEN(7), .A2_LEN(5), .CNT_SIZ(3)) dut7 (
    .clk(clk), .rst_n(rst_n), .bus(b7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic sm);
    logic signed [64:0] xe, ye;
    xe = sm ? {{33{x[31]}}, x} : {33'b0, x};
    ye = sm ? {{33{y[31]}}, y} : {33'b0, y};
    return 64'(xe * ye);
  endfunction

  function automatic logic [11:0] ref7(input logic [6:0] x, input logic [4:0] y, input logic sm);
    logic signed [12:0] xe, ye;
    xe = sm ? {{6{x[6]}}, x} : {6'b0, x};
    ye = sm ? {{8{y[4]}}, y} : {8'b0, y};
    return 12'(xe * ye);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whenever a product is presented, it must equal the reference for the current operation
  always @(negedge clk) begin
    if (rst_n) begin
      if (b32.fin) check_output("outn32_model", b32.outn, exp32);
      if (b7.fin)  check_output("outn7_model", 64'(b7.outn), 64'(exp7));
    end
  end

  // Edges are counted with the load edge as edge 1; fin must first read high after edge ITER+1
  task automatic apply_stimulus(input logic sm, input logic [31:0] x, input logic [31:0] y,
                                input logic use_lit, input logic [63:0] lit, input string name);
    int  edges;
    bit  busy_ok;
    @(negedge clk);
    check_output({name, "_busy_idle"}, 64'(b32.busy), 64'd0);
    exp32           = ref32(x, y, sm);
    b32.signed_mode = sm;
    b32.a1          = x;
    b32.a2          = y;
    b32.arm         = 1'b1;
    @(posedge clk);
    edges   = 1;
    busy_ok = 1'b1;
    @(negedge clk);
    b32.a1 = ~x;
    b32.a2 = ~y;
    b32.signed_mode = ~sm;
    while (!b32.fin && edges < 40) begin
      if (!b32.busy) busy_ok = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check_output({name, "_fin_edge"}, 64'(edges), 64'd18);
    check_output({name, "_busy_run"}, 64'(busy_ok), 64'd1);
    check_output({name, "_busy_done"}, 64'(b32.busy), 64'd0);
    if (use_lit) check_output({name, "_outn"}, b32.outn, lit);
    @(posedge clk);
    @(negedge clk);
    check_output({name, "_fin_held"}, 64'(b32.fin), 64'd1);
    b32.arm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output({name, "_fin_drop"}, 64'(b32.fin), 64'd0);
  endtask

  task automatic apply_stimulus_small(input logic sm, input logic [6:0] x, input logic [4:0] y,
                                      input logic use_lit, input logic [11:0] lit, input string name);
    int edges;
    @(negedge clk);
    exp7           = ref7(x, y, sm);
    b7.signed_mode = sm;
    b7.a1          = x;
    b7.a2          = y;
    b7.arm         = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    while (!b7.fin && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (use_lit) begin
      check_output({name, "_fin_edge"}, 64'(edges), 64'd4);
      check_output({name, "_outn"}, 64'(b7.outn), 64'(lit));
    end else if (edges != 4) begin
      check_output({name, "_fin_edge"}, 64'(edges), 64'd4);
    end
    b7.arm = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    exp32   = '0;
    exp7    = '0;
    rst_n   = 1'b0;
    b32.arm = 1'b0; b32.signed_mode = 1'b0; b32.a1 = '0; b32.a2 = '0;
    b7.arm  = 1'b0; b7.signed_mode  = 1'b0; b7.a1  = '0; b7.a2  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_outn32", b32.outn, 64'd0);
    check_output("reset_fin32", 64'(b32.fin), 64'd0);
    check_output("reset_busy32", 64'(b32.busy), 64'd0);
    check_output("reset_outn7", 64'(b7.outn), 64'd0);
    rst_n = 1'b1;

    apply_stimulus(1'b1, 32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFF_FFFFFFEB, "s_small");
    apply_stimulus(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001, "u_full");
    apply_stimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001, "s_minus1");
    apply_stimulus(1'b1, 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "s_minmin");
    apply_stimulus(1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC0000000_80000000, "s_minmax");
    apply_stimulus(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 64'h0B00EA4E_242D2080, "u_mixed");

    // Abort: arm drops before the fifth RUN edge
    @(negedge clk);
    b32.signed_mode = 1'b0; b32.a1 = 32'd99; b32.a2 = 32'd77; b32.arm = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    b32.arm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("abort_busy", 64'(b32.busy), 64'd0);
    check_output("abort_fin", 64'(b32.fin), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("abort_fin_later", 64'(b32.fin), 64'd0);
    apply_stimulus(1'b0, 32'd5, 32'd6, 1'b1, 64'd30, "rearm");

    // Asynchronous reset pulsed between edges in the middle of an operation
    @(negedge clk);
    b32.signed_mode = 1'b0; b32.a1 = 32'd12345; b32.a2 = 32'd678; b32.arm = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    check_output("pre_reset_busy", 64'(b32.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_output("areset_outn", b32.outn, 64'd0);
    check_output("areset_fin", 64'(b32.fin), 64'd0);
    check_output("areset_busy", 64'(b32.busy), 64'd0);
    b32.arm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 32'd2, 32'd3, 1'b1, 64'd6, "post_reset");

    apply_stimulus_small(1'b1, 7'h40, 5'h10, 1'b1, 12'h400, "odd_s_min");
    apply_stimulus_small(1'b0, 7'h7F, 5'h1F, 1'b1, 12'hF61, "odd_u_max");
    apply_stimulus_small(1'b1, 7'h7F, 5'h1F, 1'b1, 12'h001, "odd_s_m1");

    for (int sm = 0; sm < 2; sm++) begin
      for (int x = 0; x < 128; x++) begin
        for (int y = 0; y < 32; y++) begin
          apply_stimulus_small(sm[0], x[6:0], y[4:0], 1'b0, 12'h000, "odd_sweep");
        end
      end
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
